gshare_branch_predictor: RTL
============================

// Module: gshare_branch_predictor
// PURPOSE
//  Parametrised successor to the 5-bit bimodal predictor used by hazard detection. A table of
//  2^INDEX_BITS saturating counters is indexed by the fetch PC, optionally XOR-ed with a global
//  history register (gshare). Fetch gets a same-cycle prediction; WB resolves the branch and trains.
//  Also keeps lookup/mispredict statistics for perf runs.
// PARAMETERS
//  INDEX_BITS  5  log2 of table entries; index taken from pc[INDEX_BITS:1]
//  HIST_BITS   4  global history length; legal range 0..INDEX_BITS (0 => pure bimodal)
//  CTR_BITS    2  saturating counter width, >=1; MSB=1 predicts taken
//  GSHARE      1  1: index = pc bits XOR {0s,ghr}; 0: PC-only index, ghr kept but unused
//  STAT_BITS  16  width of statistics counters
// PORTS
//  clk              in   1           clock, all state on rising edge
//  rst_n            in   1           synchronous active-low reset
//  lookup_valid     in   1           IF holds a conditional br (op_br, nzp!=000)
//  lookup_pc        in   16          lc3b_word fetch address of that br
//  pred_taken       out  1           prediction, combinational from lookup_pc/ghr/table
//  pred_index       out  INDEX_BITS  index used; carried down pipeline with the br
//  update_valid     in   1           WB resolves a conditional br this cycle
//  update_index     in   INDEX_BITS  pred_index that travelled with the br
//  update_taken     in   1           actual outcome (br_enable)
//  update_pred      in   1           prediction that travelled with the br
//  mispredict       out  1           comb: update_valid & (update_taken != update_pred)
//  ghr_out          out  HIST_BITS   current committed history (debug), min width 1
//  stat_lookups     out  STAT_BITS   count of lookup_valid cycles, saturating
//  stat_mispredicts out  STAT_BITS   count of mispredict cycles, saturating
//  stat_clear       in   1           sync clear of both stat counters
// BEHAVIOUR
//  Reset (rst_n=0 at edge): all counters = weakly-not-taken (0b01.. i.e. 2^(CTR_BITS-1)-1),
//   ghr=0, stats=0. Reset wins over every other input incl. in-flight updates (dropped).
//  Outputs after reset: pred_taken=0 for any PC, mispredict=0 unless update_valid, ghr_out=0.
//  Lookup: index = pc[INDEX_BITS:1] ^ (GSHARE ? zero-extend(ghr) : 0); pred_taken = ctr[index]
//   MSB; zero latency. pred_index valid even when lookup_valid=0 (don't-care then).
//  Update (update_valid=1, next edge): ctr[update_index] += 1 if taken, -= 1 if not;
//   saturate at all-ones / zero, no wrap. ghr <= {ghr[HIST_BITS-2:0], update_taken}.
//  History is committed-only (updated at WB, never speculatively); no recovery logic needed.
//  Same-cycle lookup and update to same index: prediction shows OLD counter value (no bypass);
//   new value visible the following cycle. Likewise lookup index uses pre-update ghr.
//  update_valid=0: table and ghr hold. lookup_valid has no effect on table state.
//  Stats: stat_lookups += lookup_valid; stat_mispredicts += mispredict; each sticks at
//   2^STAT_BITS-1. stat_clear has priority over increment; rst_n over stat_clear.
//  HIST_BITS=0: ghr is a 1-bit constant 0, index = PC bits only.
//  Elaboration error if HIST_BITS>INDEX_BITS or CTR_BITS<1.
// STRUCTURE
//  lc3b_types gains: BP_INDEX_BITS_DEFAULT, BP_CTR_BITS_DEFAULT, and a helper function
//   bp_sat_step(ctr, taken) is NOT shared (width-parametric; keep local).
//  One sub-module: bp_counter_table (INDEX_BITS, CTR_BITS): async read port, one sync
//   write port with saturating inc/dec, sync reset init. Top holds ghr, index hash, stats.
//  hazard_detection swaps branch_predictor for this block; pred_index/pred join pipe regs.
// TESTING
//  1 Reset, lookup pc=x0000..x003E -> pred_taken=0 everywhere, ghr_out=0, stats=0.
//  2 GSHARE=0: two taken updates idx 3 -> pred at pc=x0006 becomes 1 after 1st update;
//    4 more taken -> ctr stays 11; 3 not-taken -> pred 0 after 2nd (11->10->01).
//  3 GSHARE=1,HIST_BITS=4: updates T,T,F,T -> ghr=0b1101; lookup pc=x0000 -> pred_index=13.
//  4 Same-cycle update idx 5 taken and lookup pc=x000A (ctr=01) -> pred_taken=0 that cycle,
//    1 next cycle.
//  5 update_pred=1, update_taken=0 -> mispredict=1 same cycle; stat_mispredicts +1; force
//    stats to all-ones with STAT_BITS=4 -> holds 15; stat_clear+lookup same cycle -> 0.
//  6 rst_n low during update_valid=1 -> table stays reset value, ghr=0, update lost.

Source files
------------

// File: rtl/gshare_branch_predictor_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : gshare_branch_predictor_pkg                                     |
// | Purpose  : Shared default sizes for the gshare branch predictor slice.     |
// | Contents : BP_PC_BITS, BP_INDEX_BITS_DEFAULT, BP_HIST_BITS_DEFAULT,        |
// |            BP_CTR_BITS_DEFAULT, BP_STAT_BITS_DEFAULT                       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package gshare_branch_predictor_pkg;

  // Width of an lc3b_word fetch address.
  localparam int BP_PC_BITS            = 16;
  localparam int BP_INDEX_BITS_DEFAULT = 5;
  localparam int BP_HIST_BITS_DEFAULT  = 4;
  localparam int BP_CTR_BITS_DEFAULT   = 2;
  localparam int BP_STAT_BITS_DEFAULT  = 16;

endpackage : gshare_branch_predictor_pkg
`default_nettype wire

// File: rtl/gshare_branch_predictor_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : gshare_branch_predictor_if                                      |
// | Purpose  : Lookup (IF), update (WB) and statistics signals of the branch   |
// |            predictor. master = pipeline side, slave = predictor.           |
// | Signals  : lookup_valid/lookup_pc -> pred_taken/pred_index                 |
// |            update_valid/index/taken/pred -> mispredict                     |
// |            ghr_out, stat_lookups, stat_mispredicts, stat_clear             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface gshare_branch_predictor_if
  import gshare_branch_predictor_pkg::*;
#(
  parameter int INDEX_BITS = BP_INDEX_BITS_DEFAULT,
  parameter int HIST_BITS  = BP_HIST_BITS_DEFAULT,
  parameter int STAT_BITS  = BP_STAT_BITS_DEFAULT
);
  // History output keeps at least one bit even for a pure bimodal build.
  localparam int c_GHR_W = (HIST_BITS > 0) ? HIST_BITS : 1;

  logic                  lookup_valid;
  logic [BP_PC_BITS-1:0] lookup_pc;
  logic                  pred_taken;
  logic [INDEX_BITS-1:0] pred_index;

  logic                  update_valid;
  logic [INDEX_BITS-1:0] update_index;
  logic                  update_taken;
  logic                  update_pred;
  logic                  mispredict;

  logic [c_GHR_W-1:0]    ghr_out;
  logic [STAT_BITS-1:0]  stat_lookups;
  logic [STAT_BITS-1:0]  stat_mispredicts;
  logic                  stat_clear;

  modport master (
    output lookup_valid, lookup_pc, update_valid, update_index, update_taken,
           update_pred, stat_clear,
    input  pred_taken, pred_index, mispredict, ghr_out, stat_lookups,
           stat_mispredicts
  );

  modport slave (
    input  lookup_valid, lookup_pc, update_valid, update_index, update_taken,
           update_pred, stat_clear,
    output pred_taken, pred_index, mispredict, ghr_out, stat_lookups,
           stat_mispredicts
  );

endinterface : gshare_branch_predictor_if
`default_nettype wire

// File: rtl/gshare_branch_predictor_bp_counter_table.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bp_counter_table                                                |
// | Purpose  : 2^INDEX_BITS saturating counters. Asynchronous read port, one   |
// |            synchronous write port that steps a counter up (taken) or down. |
// | Ports    : clk, rst_n       - clock, sync active-low reset (weakly-not-tkn) |
// |            rd_index/rd_ctr  - combinational read                           |
// |            wr_en/wr_index/wr_taken - saturating increment / decrement      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module bp_counter_table
  import gshare_branch_predictor_pkg::*;
#(
  parameter int INDEX_BITS = BP_INDEX_BITS_DEFAULT,
  parameter int CTR_BITS   = BP_CTR_BITS_DEFAULT
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic [INDEX_BITS-1:0] rd_index,
  output logic      [CTR_BITS-1:0]   rd_ctr,
  input  wire logic                  wr_en,
  input  wire logic [INDEX_BITS-1:0] wr_index,
  input  wire logic                  wr_taken
);
  localparam int c_ENTRIES = 1 << INDEX_BITS;
  // Weakly-not-taken: MSB clear, all lower bits set (0 for a 1-bit counter).
  localparam logic [CTR_BITS-1:0] c_CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

  logic [CTR_BITS-1:0] r_table [c_ENTRIES];

  function automatic logic [CTR_BITS-1:0] bp_sat_step(
    input logic [CTR_BITS-1:0] ctr,
    input logic                taken
  );
    logic [CTR_BITS-1:0] nxt;
    nxt = ctr;
    if (taken) begin
      if (!(&ctr)) nxt = ctr + CTR_BITS'(1);
    end else begin
      if (|ctr) nxt = ctr - CTR_BITS'(1);
    end
    return nxt;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < c_ENTRIES; i++) begin
        r_table[i] <= c_CTR_INIT;
      end
    end else if (wr_en) begin
      r_table[wr_index] <= bp_sat_step(r_table[wr_index], wr_taken);
    end
  end

  // No write-to-read bypass: a same-cycle update becomes visible next cycle.
  assign rd_ctr = r_table[rd_index];

endmodule : bp_counter_table
`default_nettype wire

// File: rtl/gshare_branch_predictor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : gshare_branch_predictor                                         |
// | Purpose  : gshare / bimodal conditional-branch predictor. Same-cycle       |
// |            prediction for fetch, training and committed global history     |
// |            update at WB, saturating lookup / mispredict statistics.        |
// | Ports    : clk    - clock, all state on rising edge                        |
// |            rst_n  - synchronous active-low reset                           |
// |            bp     - gshare_branch_predictor_if.slave (lookup, update,      |
// |                     mispredict, ghr_out, stat_* and stat_clear)            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module gshare_branch_predictor
  import gshare_branch_predictor_pkg::*;
#(
  parameter int INDEX_BITS = BP_INDEX_BITS_DEFAULT,
  parameter int HIST_BITS  = BP_HIST_BITS_DEFAULT,
  parameter int CTR_BITS   = BP_CTR_BITS_DEFAULT,
  parameter int GSHARE     = 1,
  parameter int STAT_BITS  = BP_STAT_BITS_DEFAULT
) (
  input wire logic                 clk,
  input wire logic                 rst_n,
  gshare_branch_predictor_if.slave bp
);
  localparam int c_GHR_W = (HIST_BITS > 0) ? HIST_BITS : 1;

  generate
    if (HIST_BITS > INDEX_BITS || HIST_BITS < 0 || CTR_BITS < 1 ||
        INDEX_BITS < 1 || INDEX_BITS > BP_PC_BITS - 1) begin : g_bad_params
      $error("gshare_branch_predictor: illegal INDEX_BITS/HIST_BITS/CTR_BITS");
    end
  endgenerate

  logic [c_GHR_W-1:0]    w_ghr;
  logic [INDEX_BITS-1:0] w_pc_index;
  logic [INDEX_BITS-1:0] w_index;
  logic [CTR_BITS-1:0]   w_rd_ctr;
  logic                  w_mispredict;
  logic [STAT_BITS-1:0]  r_stat_lookups;
  logic [STAT_BITS-1:0]  r_stat_mispredicts;
  logic                  w_unused_bits;

  // Committed history: shifted only when WB resolves a branch.
  generate
    if (HIST_BITS == 0) begin : g_no_hist
      assign w_ghr = 1'b0;
    end else begin : g_hist
      logic [c_GHR_W-1:0] r_ghr;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_ghr <= '0;
        end else if (bp.update_valid) begin
          // Low c_GHR_W bits of {ghr, taken} = {ghr[H-2:0], taken}; works for H=1 too.
          r_ghr <= c_GHR_W'({r_ghr, bp.update_taken});
        end
      end
      assign w_ghr = r_ghr;
    end
  endgenerate

  // Index hash: pc bit 0 is always zero for word-aligned fetch, so skip it.
  assign w_pc_index = bp.lookup_pc[INDEX_BITS:1];
  generate
    if (GSHARE != 0 && HIST_BITS > 0) begin : g_gshare_hash
      assign w_index = w_pc_index ^ INDEX_BITS'(w_ghr);
    end else begin : g_pc_hash
      assign w_index = w_pc_index;
    end
  endgenerate

  bp_counter_table #(
    .INDEX_BITS (INDEX_BITS),
    .CTR_BITS   (CTR_BITS)
  ) u_table (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_index (w_index),
    .rd_ctr   (w_rd_ctr),
    .wr_en    (bp.update_valid),
    .wr_index (bp.update_index),
    .wr_taken (bp.update_taken)
  );

  assign w_mispredict = bp.update_valid & (bp.update_taken != bp.update_pred);

  // Statistics: clear beats increment, each counter sticks at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stat_lookups     <= '0;
      r_stat_mispredicts <= '0;
    end else if (bp.stat_clear) begin
      r_stat_lookups     <= '0;
      r_stat_mispredicts <= '0;
    end else begin
      if (bp.lookup_valid && !(&r_stat_lookups)) begin
        r_stat_lookups <= r_stat_lookups + STAT_BITS'(1);
      end
      if (w_mispredict && !(&r_stat_mispredicts)) begin
        r_stat_mispredicts <= r_stat_mispredicts + STAT_BITS'(1);
      end
    end
  end

  assign bp.pred_taken       = w_rd_ctr[CTR_BITS-1];
  assign bp.pred_index       = w_index;
  assign bp.mispredict       = w_mispredict;
  assign bp.ghr_out          = w_ghr;
  assign bp.stat_lookups     = r_stat_lookups;
  assign bp.stat_mispredicts = r_stat_mispredicts;

  // PC bits outside the index field and the counter's low bits are not needed.
  assign w_unused_bits = ^{bp.lookup_pc[0], (bp.lookup_pc >> (INDEX_BITS + 1)), w_rd_ctr};

endmodule : gshare_branch_predictor
`default_nettype wire
